argmax_classifier: RTL
======================

Name: argmax_classifier

Overview:
- Sits directly downstream of the neuron array in the output layer.
- Consumes one activated neuron result per handshake, in class-index order 0..NUM_CLASSES-1.
- Tracks the running maximum score and its index.
- After the last class, presents the winning class and score on a valid/ready output port; then re-arms for the next inference.

Parameters:
- data_size, 32, neuron operand width; results and scores are 2*data_size bits wide
- NUM_CLASSES, 10, number of neuron results per inference; legal range 2..256
- IDX_W, $clog2(NUM_CLASSES), width of the class index (localparam, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data holds a neuron result
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  2*data_size  activated neuron result (result_out format)
- out_valid  output  1  classification result available
- out_ready  input  1  consumer takes the result this cycle
- out_class  output  IDX_W  index of the maximum score
- out_score  output  2*data_size  maximum score
- busy  output  1  at least one result of the current inference accepted, output not yet taken

Behaviour:
- Single clock; rst is asynchronous and active-low, applied on assertion and released synchronously to clk.
- FSM states:
  - COLLECT (reset state): in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset values: state=COLLECT, cnt=0, max_score=0, max_idx=0, out_valid=0, in_ready=1 after release, out_class=0, out_score=0, busy=0.
- Accept = in_valid & in_ready. On each accept in COLLECT:
  - If cnt==0: max_score<=in_data, max_idx<=0 unconditionally.
  - Else if in_data > max_score: max_score<=in_data, max_idx<=cnt.
  - cnt increments; busy<=1.
- Compare is unsigned (full 2*data_size bits, no truncation). Ties keep the earlier (lower) index; only strictly greater replaces.
- Accept with cnt==NUM_CLASSES-1: next state DONE, cnt<=0. out_valid rises the cycle after the last accept (latency 1).
- out_class/out_score are registered copies of max_idx/max_score and stay stable while out_valid=1 && out_ready=0.
- In DONE, in_valid is ignored (in_ready=0). No input is lost, because the producer holds it.
- In DONE with out_ready=1: handshake completes, next state COLLECT, busy<=0, in_ready=1 the following cycle. There is no same-cycle input acceptance at the DONE->COLLECT edge.
- out_ready while out_valid=0 has no effect.
- in_valid gaps (bubbles) in COLLECT stall the count; no timeout.
- rst asserted mid-inference or in DONE: partial state discarded immediately, all outputs return to reset values, the next accepted input is class 0.
- Counter never wraps past NUM_CLASSES-1. cnt width is IDX_W, and the NUM_CLASSES=2^IDX_W case must be handled.

Optional Feature:
- Macro: ARGMAX_SIGNED_EN.
- Defined: in_data and max_score are compared as two's-complement signed values; the cnt==0 rule is unchanged. Use this when neurons are built without the ReLU stage.
- Undefined: unsigned compare as specified above.
- Port list is identical in both builds.

Decomposition:
- Shared package nn_pkg holds:
  - DATA_SIZE default (32), NUM_CLASSES default (10)
  - typedef result_t = logic [2*DATA_SIZE-1:0]
  - typedef enum logic {COLLECT, DONE} argmax_state_e
- One sub-module: argmax_cmp, combinational. Inputs candidate and current max; output gt. It holds the signed/unsigned selection under ARGMAX_SIGNED_EN, so the FSM stays compare-agnostic.

Test Plan:
1. Reset then stream 10 results {3,9,1,7,9,0,2,8,4,5} with in_valid held high -> out_valid one cycle after 10th accept, out_class=1, out_score=9 (tie at index 4 ignored).
2. Stream all-zero results -> out_class=0, out_score=0; out_valid held 5 cycles with out_ready=0, outputs stable; in_ready=0 throughout DONE.
3. Stream with random in_valid bubbles, max 64'hFFFF_FFFF_FFFF_FFFF at class 9 -> out_class=9, out_score all-ones; exactly 10 accepts counted.
4. Back-to-back inferences: complete handshake, then second stream {0,0,5,0,0,0,0,0,0,0} -> out_class=2, out_score=5; no carry-over from the first inference.
5. Assert rst low after 6 accepts, release, stream {1,2,3,4,5,6,7,8,9,10} -> out_class=9, out_score=10; busy=0 and out_valid=0 during reset.
6. With ARGMAX_SIGNED_EN, stream {-5,-2,-9,-2,-7,-8,-3,-4,-6,-10} (64-bit) -> out_class=1, out_score=-2; without the macro the same stream gives out_class=1, out_score=64'hFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and defaults for the output-layer neural network blocks.
package nn_pkg;

    localparam int DATA_SIZE           = 32;
    localparam int NUM_CLASSES_DEFAULT = 10;

    typedef logic [2*DATA_SIZE-1:0] result_t;

    typedef enum logic {
        COLLECT,
        DONE
    } argmax_state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Strict greater-than compare of a candidate score against the running max.
// ARGMAX_SIGNED_EN selects two's-complement compare; default is unsigned.
module argmax_cmp #(
    parameter int W = 64
) (
    input  logic [W-1:0] cand_i,
    input  logic [W-1:0] max_i,
    output logic         gt_o
);

`ifdef ARGMAX_SIGNED_EN
    assign gt_o = $signed(cand_i) > $signed(max_i);
`else
    assign gt_o = cand_i > max_i;
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Running argmax over one neuron result per class; emits winner on valid/ready.
// ARGMAX_SIGNED_EN switches the score compare to signed (see argmax_cmp).
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int data_size   = nn_pkg::DATA_SIZE,
    parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES_DEFAULT,
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*data_size-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_class,
    output logic [2*data_size-1:0] out_score,
    output logic                   busy
);

    localparam int RW = 2*data_size;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES-1);

    argmax_state_e    state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    max_score_q, max_score_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W-1:0] out_class_q, out_class_d;
    logic [RW-1:0]    out_score_q, out_score_d;
    logic             busy_q, busy_d;

    logic             gt;
    logic             accept;
    logic             take_new;
    logic [RW-1:0]    new_score;
    logic [IDX_W-1:0] new_idx;

    argmax_cmp #(
        .W(RW)
    ) u_cmp (
        .cand_i(in_data),
        .max_i (max_score_q),
        .gt_o  (gt)
    );

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == DONE);
    assign out_class = out_class_q;
    assign out_score = out_score_q;
    assign busy      = busy_q;

    assign accept = in_valid & in_ready;

    // Class 0 always seeds the max; later classes replace only on strict win.
    assign take_new  = (cnt_q == '0) || gt;
    assign new_score = take_new ? in_data : max_score_q;
    assign new_idx   = take_new ? cnt_q : max_idx_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        max_score_d = max_score_q;
        max_idx_d   = max_idx_q;
        out_class_d = out_class_q;
        out_score_d = out_score_q;
        busy_d      = busy_q;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    busy_d      = 1'b1;
                    max_score_d = new_score;
                    max_idx_d   = new_idx;
                    if (cnt_q == LAST) begin
                        cnt_d       = '0;
                        state_d     = DONE;
                        out_score_d = new_score;
                        out_class_d = new_idx;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = COLLECT;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            max_score_q <= '0;
            max_idx_q   <= '0;
            out_class_q <= '0;
            out_score_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_score_q <= max_score_d;
            max_idx_q   <= max_idx_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
            busy_q      <= busy_d;
        end
    end

endmodule
